cva6_ptw_sv32_walker: RTL and testbench
=======================================

// Module: cva6_ptw_sv32_walker
// PURPOSE
//  Sv32 hardware page-table walker that fills cva6_tlb_sv32 on a miss. Accepts one miss (vaddr, asid),
//  fetches PTEs from memory over a req/gnt/rvalid port and emits a one-cycle update_o to the TLB.
//  It is the producer side of the TLB update interface. Detected page faults are reported instead of an update.
// PARAMETERS
//  ASID_WIDTH  1   width of miss_asid_i; zero-extended to 9 bits in update_o
// PORTS
//  clk_i          in   1          clock, rising edge
//  rst_ni         in   1          reset; asynchronous, active-low
//  flush_i        in   1          abort any walk (sfence.vma)
//  satp_ppn_i     in   22         root page-table PPN
//  miss_valid_i   in   1          miss request valid
//  miss_ready_o   out  1          walker idle; accepts a miss
//  miss_vaddr_i   in   32         missing virtual address
//  miss_asid_i    in   ASID_WIDTH ASID of the miss
//  mem_req_o      out  1          PTE read request; held until mem_gnt_i
//  mem_addr_o     out  34         PTE physical address
//  mem_gnt_i      in   1          request accepted
//  mem_rvalid_i   in   1          read data valid, at least 1 cycle after gnt
//  mem_rdata_i    in   32         PTE
//  update_o       out  63         {valid, is_4M, vpn[19:0], asid[8:0], content[31:0]} to TLB
//  walk_busy_o    out  1          walk in progress, including DRAIN
//  fault_o        out  1          one-cycle page-fault pulse
//  fault_vaddr_o  out  32         faulting vaddr, valid with fault_o
// BEHAVIOUR
//  Reset: state IDLE; miss_ready_o=1; mem_req_o=0, mem_addr_o=0; update_o=0; busy=0; fault_o=0, fault_vaddr_o=0.
//  FSM: IDLE -> L1_REQ -> L1_WAIT -> [L0_REQ -> L0_WAIT] -> IDLE. DRAIN absorbs an outstanding response.
//  IDLE: miss_ready_o=1. When miss_valid_i=1, latch vaddr, asid and satp_ppn_i, then go to L1_REQ.
//  L1_REQ: mem_req_o=1, mem_addr_o={satp_ppn,vaddr[31:22],2'b00}; gnt -> L1_WAIT.
//  L1_WAIT: on rvalid decode PTE. V=bit0, R=bit1, W=bit2, X=bit3, ppn=pte[31:10].
//   Fault if V=0, or R=0 with W=1.
//   Leaf (R|X): if pte[19:10]!=0 (misaligned superpage), fault; else update with is_4M=1.
//   Non-leaf: go to L0_REQ with addr={pte[31:10],vaddr[21:12],2'b00}.
//  L0_REQ/L0_WAIT: same handshake. Fault if V=0, R=0 with W=1, or non-leaf. Else update with is_4M=0.
//  Update: the cycle after the accepted rvalid, update_o[62]=1 for exactly one cycle with:
//   vpn=vaddr[31:12]; asid zero-extended to 9 bits; content=raw PTE. Then return to IDLE.
//   When update_o[62]=0, all update_o bits are 0.
//  Fault: fault_o=1 with fault_vaddr_o for one cycle, the cycle after rvalid; no update; return to IDLE.
//  Latency with gnt and rvalid each 1 cycle after request:
//   4M leaf: accept at cycle 0, update at cycle 3. 4K leaf: update at cycle 5.
//  flush_i, highest priority:
//   IDLE: no effect; a miss accepted in the same cycle is dropped.
//   *_REQ without gnt that cycle: deassert req, go to IDLE.
//   *_REQ with gnt that cycle, or *_WAIT without rvalid: go to DRAIN; discard the next rvalid, then IDLE.
//   *_WAIT with rvalid that cycle: discard the data, go to IDLE; no update, no fault.
//  miss_ready_o=0 in every state except IDLE; busy = !IDLE. At most one outstanding memory read.
//  Async reset mid-walk: immediately IDLE; a later stray rvalid is ignored in IDLE.
//  mem_addr_o stays stable while mem_req_o=1 without gnt (no retract except on flush).
// STRUCTURE
//  Package cva6_ptw_sv32_pkg:
//   pte_t struct (ppn1[11:0], ppn0[9:0], rsw, d, a, g, u, x, w, r, v).
//   tlb_update_t packed struct matching the 63-bit layout; state_e enum.
//   Functions is_leaf(pte_t) and is_invalid(pte_t).
//  Single module, no sub-module; one registered FSM plus latched vaddr/asid/ppn/level registers.
// TESTING
//  1) satp_ppn=0x00010, vaddr=0x0040_3000; L1 PTE 0x0000_0401 (non-leaf); L0 PTE 0x2000_00CF
//     -> L1 addr 0x0_0001_0004, L0 addr 0x0_0000_100C; update is_4M=0, vpn=0x00403, content=0x2000_00CF.
//  2) vaddr=0x8000_0000; L1 PTE 0x2000_00CF (aligned leaf)
//     -> one update with is_4M=1, vpn=0x80000; only one mem request.
//  3) L1 PTE 0x2000_04CF (ppn0!=0) -> fault_o=1, fault_vaddr_o=vaddr, update_o=0.
//     L0 PTE 0x0000_0000 -> fault_o=1.
//  4) flush_i in L1_WAIT before rvalid -> DRAIN; the following rvalid produces no update;
//     miss_ready_o=1 the cycle after.
//  5) mem_gnt_i held low 5 cycles -> mem_req_o and mem_addr_o stable; miss_valid_i ignored; busy=1.
//  6) rst_ni low during L0_WAIT -> all outputs at reset values the same cycle; a later rvalid is ignored.

Source files
------------

// File: rtl/cva6_ptw_sv32_pkg.sv
// Shared types for the Sv32 page-table walker: PTE layout, TLB update word and walker states.
// Also holds the PTE classification helpers used when a memory response is decoded.
package cva6_ptw_sv32_pkg;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    // Field order matches the 63-bit update word consumed by cva6_tlb_sv32.
    typedef struct packed {
        logic        valid;
        logic        is_4m;
        logic [19:0] vpn;
        logic [8:0]  asid;
        pte_t        content;
    } tlb_update_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DRAIN
    } state_e;

    function automatic logic is_leaf(pte_t p);
        return p.r | p.x;
    endfunction

    // Reserved encoding (writable but not readable) is treated like an invalid entry.
    function automatic logic is_invalid(pte_t p);
        return !p.v || (!p.r && p.w);
    endfunction

endpackage

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 hardware page-table walker: one miss at a time, two-level PTE fetch over req/gnt/rvalid,
// producing a one-cycle TLB update or a page-fault pulse. flush_i aborts, draining any outstanding read.
module cva6_ptw_sv32_walker
    import cva6_ptw_sv32_pkg::*;
#(
    parameter int ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [21:0]           satp_ppn_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    output logic                  mem_req_o,
    output logic [33:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  walk_busy_o,
    output logic                  fault_o,
    output logic [31:0]           fault_vaddr_o
);

    state_e                state, state_next;
    logic [31:0]           vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [21:0]           ppn_q;
    tlb_update_t           update_q, update_d;
    logic                  fault_q, fault_d;
    logic [31:0]           fault_vaddr_q;
    pte_t                  pte;

    assign pte           = pte_t'(mem_rdata_i);
    assign update_o      = update_q;
    assign fault_o       = fault_q;
    assign fault_vaddr_o = fault_vaddr_q;

    // ppn_q holds the table base of the level being fetched: satp at L1, the L1 pointer at L0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            vaddr_q       <= '0;
            asid_q        <= '0;
            ppn_q         <= '0;
            update_q      <= '0;
            fault_q       <= 1'b0;
            fault_vaddr_q <= '0;
        end else begin
            state         <= state_next;
            update_q      <= update_d;
            fault_q       <= fault_d;
            fault_vaddr_q <= fault_d ? vaddr_q : '0;
            if (state == IDLE && miss_valid_i) begin
                vaddr_q <= miss_vaddr_i;
                asid_q  <= miss_asid_i;
                ppn_q   <= satp_ppn_i;
            end else if (state == L1_WAIT && state_next == L0_REQ) begin
                ppn_q <= {pte.ppn1, pte.ppn0};
            end
        end
    end

    // Flush wins over every other event; a granted-but-unanswered read must be drained.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (miss_valid_i && !flush_i) state_next = L1_REQ;
            end
            L1_REQ, L0_REQ: begin
                if (flush_i)        state_next = mem_gnt_i ? DRAIN : IDLE;
                else if (mem_gnt_i) state_next = (state == L1_REQ) ? L1_WAIT : L0_WAIT;
            end
            L1_WAIT: begin
                if (flush_i)           state_next = mem_rvalid_i ? IDLE : DRAIN;
                else if (mem_rvalid_i) state_next = (is_invalid(pte) || is_leaf(pte)) ? IDLE : L0_REQ;
            end
            L0_WAIT: begin
                if (flush_i)           state_next = mem_rvalid_i ? IDLE : DRAIN;
                else if (mem_rvalid_i) state_next = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        miss_ready_o     = (state == IDLE);
        walk_busy_o      = (state != IDLE);
        mem_req_o        = 1'b0;
        mem_addr_o       = '0;
        update_d         = '0;
        fault_d          = 1'b0;
        update_d.vpn     = '0;
        case (state)
            L1_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {ppn_q, vaddr_q[31:22], 2'b00};
            end
            L0_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {ppn_q, vaddr_q[21:12], 2'b00};
            end
            L1_WAIT: begin
                if (mem_rvalid_i && !flush_i) begin
                    // A superpage leaf must have ppn0 clear, otherwise it is misaligned.
                    if (is_invalid(pte) || (is_leaf(pte) && pte.ppn0 != '0)) begin
                        fault_d = 1'b1;
                    end else if (is_leaf(pte)) begin
                        update_d.valid   = 1'b1;
                        update_d.is_4m   = 1'b1;
                        update_d.vpn     = vaddr_q[31:12];
                        update_d.asid    = 9'(asid_q);
                        update_d.content = pte;
                    end
                end
            end
            L0_WAIT: begin
                if (mem_rvalid_i && !flush_i) begin
                    if (is_invalid(pte) || !is_leaf(pte)) begin
                        fault_d = 1'b1;
                    end else begin
                        update_d.valid   = 1'b1;
                        update_d.is_4m   = 1'b0;
                        update_d.vpn     = vaddr_q[31:12];
                        update_d.asid    = 9'(asid_q);
                        update_d.content = pte;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
// Bench for cva6_ptw_sv32_walker: directed walks, flush/reset corner cases and randomized walks
// against a page-table reference model over a sparse memory image.
module tb_cva6_ptw_sv32_walker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [21:0] satp_ppn_i = '0;
    logic        miss_valid_i = 1'b0;
    logic        miss_ready_o;
    logic [31:0] miss_vaddr_i = '0;
    logic [0:0]  miss_asid_i = '0;
    logic        mem_req_o;
    logic [33:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [62:0] update_o;
    logic        walk_busy_o;
    logic        fault_o;
    logic [31:0] fault_vaddr_o;

    cva6_ptw_sv32_walker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .satp_ppn_i(satp_ppn_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_vaddr_i(miss_vaddr_i),
        .miss_asid_i(miss_asid_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .update_o(update_o), .walk_busy_o(walk_busy_o), .fault_o(fault_o),
        .fault_vaddr_o(fault_vaddr_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [33:0]];

    logic [62:0] obs_upd;
    logic        obs_flt;
    logic [31:0] obs_fva;
    logic [33:0] obs_addr[$];
    int          obs_lat, obs_events, obs_proto_err;

    logic [62:0] e_upd;
    logic        e_flt;
    int          e_nreq;
    logic [33:0] e_a1, e_a2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [33:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [33:0] qget(input int i);
        return (i < obs_addr.size()) ? obs_addr[i] : '1;
    endfunction

    // Reference walk straight from the Sv32 rules, using plain arithmetic on addresses.
    function automatic void model(input logic [21:0] satp, input logic [31:0] va, input logic asid,
                                  output logic [62:0] upd, output logic flt, output int nreq,
                                  output logic [33:0] a1, output logic [33:0] a2);
        logic [31:0] p1, p2;
        a1   = 34'(satp) * 34'd4096 + 34'(va >> 22) * 34'd4;
        p1   = rd(a1);
        nreq = 1; upd = '0; flt = 1'b0; a2 = '0;
        if (!p1[0] || (!p1[1] && p1[2])) begin
            flt = 1'b1;
        end else if (p1[1] || p1[3]) begin
            if (((p1 >> 10) % 1024) != 0) flt = 1'b1;
            else upd = {1'b1, 1'b1, va[31:12], 9'(asid), p1};
        end else begin
            a2   = 34'(p1 >> 10) * 34'd4096 + 34'((va >> 12) % 1024) * 34'd4;
            nreq = 2;
            p2   = rd(a2);
            if (!p2[0] || (!p2[1] && p2[2]) || !(p2[1] || p2[3])) flt = 1'b1;
            else upd = {1'b1, 1'b0, va[31:12], 9'(asid), p2};
        end
    endfunction

    function automatic logic [31:0] gen_pte(input bit prefer_table);
        logic [31:0] p;
        int k;
        p = $urandom;
        k = (prefer_table && $urandom_range(1, 0) == 1) ? 0 : $urandom_range(5, 0);
        case (k)
            0: p[3:0] = 4'b0001;
            1: begin p[0] = 1'b1; p[1] = 1'b1; p[19:10] = '0; end
            2: begin p[0] = 1'b1; p[3] = 1'b1; p[2] = 1'b0; p[10] = 1'b1; end
            3: p[0] = 1'b0;
            4: p[3:0] = 4'b0101;
            default: ;
        endcase
        return p;
    endfunction

    // Drives a miss and acts as the memory: random grant/response delays, bounded by a cycle budget.
    task automatic run_walk(input logic [31:0] va, input logic asid, input logic [21:0] satp,
                            input int gmax, input int rmax);
        bit          pending, req_seen;
        int          gcnt, rcnt;
        logic [33:0] raddr, cur_addr;
        @(negedge clk_i);
        chk("ready_idle", miss_ready_o, 1'b1);
        miss_valid_i = 1'b1; miss_vaddr_i = va; miss_asid_i = asid; satp_ppn_i = satp;
        obs_addr.delete();
        obs_upd = '0; obs_flt = 1'b0; obs_fva = '0; obs_lat = -1; obs_events = 0; obs_proto_err = 0;
        pending = 1'b0; req_seen = 1'b0; raddr = '0; cur_addr = '0; rcnt = 0;
        gcnt = $urandom_range(gmax, 0);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            if (update_o[62] || fault_o) begin
                obs_events++;
                if (obs_lat < 0) obs_lat = cyc;
                if (update_o[62]) obs_upd = update_o;
                if (fault_o) begin obs_flt = 1'b1; obs_fva = fault_vaddr_o; end
            end
            if (!update_o[62] && update_o != '0) obs_proto_err++;
            if (mem_req_o && pending) obs_proto_err++;
            miss_valid_i = (obs_events == 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            miss_vaddr_i = $urandom;
            if (pending) begin
                if (rcnt == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = rd(raddr); pending = 1'b0;
                end else rcnt--;
            end else if (mem_req_o) begin
                if (!req_seen) begin req_seen = 1'b1; cur_addr = mem_addr_o; end
                else if (mem_addr_o !== cur_addr) obs_proto_err++;
                if (gcnt == 0) begin
                    mem_gnt_i = 1'b1; pending = 1'b1; raddr = mem_addr_o; req_seen = 1'b0;
                    obs_addr.push_back(mem_addr_o);
                    rcnt = $urandom_range(rmax, 0); gcnt = $urandom_range(gmax, 0);
                end else gcnt--;
            end
            if (obs_events > 0 && cyc > obs_lat + 3) break;
        end
        miss_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    task automatic start_miss(input logic [31:0] va, input logic [21:0] satp);
        @(negedge clk_i);
        miss_valid_i = 1'b1; miss_vaddr_i = va; miss_asid_i = 1'b1; satp_ppn_i = satp;
        @(negedge clk_i);
        miss_valid_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, miss_ready_o, 1'b1);
        chk({tag, "_req"}, mem_req_o, 1'b0);
        chk({tag, "_addr"}, mem_addr_o, 34'h0);
        chk({tag, "_update"}, update_o, 63'h0);
        chk({tag, "_busy"}, walk_busy_o, 1'b0);
        chk({tag, "_fault"}, fault_o, 1'b0);
        chk({tag, "_fva"}, fault_vaddr_o, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] va, p1;
        logic [21:0] satp;
        logic        asid;
        bit          zero_delay;

        repeat (2) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_ni = 1'b1;

        // Two-level walk to a 4K leaf.
        mem.delete();
        mem[34'h0_0001_0004] = 32'h0000_0401;
        mem[34'h0_0000_100C] = 32'h2000_00CF;
        run_walk(32'h0040_3000, 1'b1, 22'h00010, 0, 0);
        chk("t1_nreq", obs_addr.size(), 2);
        chk("t1_l1addr", qget(0), 34'h0_0001_0004);
        chk("t1_l0addr", qget(1), 34'h0_0000_100C);
        chk("t1_update", obs_upd, {1'b1, 1'b0, 20'h00403, 9'h001, 32'h2000_00CF});
        chk("t1_fault", obs_flt, 1'b0);
        chk("t1_latency", obs_lat, 5);
        chk("t1_events", obs_events, 1);
        chk("t1_proto", obs_proto_err, 0);

        // Aligned superpage leaf at L1.
        mem.delete();
        mem[34'h0_0001_0800] = 32'h2000_00CF;
        run_walk(32'h8000_0000, 1'b0, 22'h00010, 0, 0);
        chk("t2_nreq", obs_addr.size(), 1);
        chk("t2_update", obs_upd, {1'b1, 1'b1, 20'h80000, 9'h000, 32'h2000_00CF});
        chk("t2_latency", obs_lat, 3);
        chk("t2_events", obs_events, 1);

        // Misaligned superpage, then an empty L0 entry.
        mem[34'h0_0001_0800] = 32'h2000_04CF;
        run_walk(32'h8000_0000, 1'b0, 22'h00010, 0, 0);
        chk("t3a_fault", obs_flt, 1'b1);
        chk("t3a_fva", obs_fva, 32'h8000_0000);
        chk("t3a_update", obs_upd, 63'h0);
        chk("t3a_events", obs_events, 1);
        mem.delete();
        mem[34'h0_0001_0004] = 32'h0000_0401;
        run_walk(32'h0040_3000, 1'b1, 22'h00010, 1, 1);
        chk("t3b_fault", obs_flt, 1'b1);
        chk("t3b_fva", obs_fva, 32'h0040_3000);
        chk("t3b_nreq", obs_addr.size(), 2);
        chk("t3b_update", obs_upd, 63'h0);

        // Flush in L1_WAIT before the response: drain and drop it.
        start_miss(32'h8000_0000, 22'h00010);
        chk("t4_req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk_i); flush_i = 1'b0;
        chk("t4_drain_busy", walk_busy_o, 1'b1);
        chk("t4_drain_ready", miss_ready_o, 1'b0);
        chk("t4_drain_req", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk_i); mem_rvalid_i = 1'b0;
        chk("t4_ready_after", miss_ready_o, 1'b1);
        chk("t4_no_update", update_o, 63'h0);
        chk("t4_no_fault", fault_o, 1'b0);
        @(negedge clk_i);
        chk("t4_no_update2", update_o, 63'h0);

        // Flush in a request state without grant: retract and go idle.
        start_miss(32'h8000_0000, 22'h00010);
        flush_i = 1'b1;
        @(negedge clk_i); flush_i = 1'b0;
        chk("t4b_req", mem_req_o, 1'b0);
        chk("t4b_ready", miss_ready_o, 1'b1);

        // Flush with grant in the same cycle: must still drain one response.
        start_miss(32'h8000_0000, 22'h00010);
        mem_gnt_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0; flush_i = 1'b0;
        chk("t4c_busy", walk_busy_o, 1'b1);
        chk("t4c_req", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk_i); mem_rvalid_i = 1'b0;
        chk("t4c_ready", miss_ready_o, 1'b1);
        chk("t4c_no_update", update_o, 63'h0);

        // Flush with the response in the same cycle: data discarded.
        start_miss(32'h8000_0000, 22'h00010);
        mem_gnt_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF; flush_i = 1'b1;
        @(negedge clk_i); mem_rvalid_i = 1'b0; flush_i = 1'b0;
        chk("t4d_ready", miss_ready_o, 1'b1);
        chk("t4d_no_update", update_o, 63'h0);
        chk("t4d_no_fault", fault_o, 1'b0);

        // Flush in IDLE drops a miss offered in the same cycle.
        miss_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i); miss_valid_i = 1'b0; flush_i = 1'b0;
        chk("t4e_ready", miss_ready_o, 1'b1);
        chk("t4e_busy", walk_busy_o, 1'b0);
        chk("t4e_req", mem_req_o, 1'b0);

        // Grant withheld for five cycles while other misses are offered.
        start_miss(32'h0040_3000, 22'h00010);
        for (int i = 0; i < 5; i++) begin
            chk("t5_req", mem_req_o, 1'b1);
            chk("t5_addr", mem_addr_o, 34'h0_0001_0004);
            chk("t5_busy", walk_busy_o, 1'b1);
            chk("t5_ready", miss_ready_o, 1'b0);
            miss_valid_i = 1'b1; miss_vaddr_i = $urandom;
            @(negedge clk_i);
        end
        miss_valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk_i); mem_rvalid_i = 1'b0;
        chk("t5_update", update_o, {1'b1, 1'b1, 20'h00403, 9'h001, 32'h2000_00CF});

        // Asynchronous reset while waiting for the L0 response.
        start_miss(32'h0040_3000, 22'h00010);
        mem_gnt_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0401;
        @(negedge clk_i); mem_rvalid_i = 1'b0;
        chk("t6_l0addr", mem_addr_o, 34'h0_0000_100C);
        mem_gnt_i = 1'b1;
        @(negedge clk_i); mem_gnt_i = 1'b0;
        chk("t6_in_wait_busy", walk_busy_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk_reset_outputs("t6_async");
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk_i); mem_rvalid_i = 1'b0;
        chk("t6_stray_update", update_o, 63'h0);
        chk("t6_stray_fault", fault_o, 1'b0);
        chk("t6_stray_ready", miss_ready_o, 1'b1);

        // Randomized page tables against the reference walk.
        for (int n = 0; n < 40; n++) begin
            mem.delete();
            va   = $urandom;
            satp = 22'($urandom);
            asid = 1'($urandom_range(1, 0));
            zero_delay = (n % 4 == 0);
            e_a1 = 34'(satp) * 34'd4096 + 34'(va >> 22) * 34'd4;
            p1   = gen_pte(1'b1);
            mem[e_a1] = p1;
            e_a2 = 34'(p1 >> 10) * 34'd4096 + 34'((va >> 12) % 1024) * 34'd4;
            if (e_a2 != e_a1) mem[e_a2] = gen_pte(1'b0);
            model(satp, va, asid, e_upd, e_flt, e_nreq, e_a1, e_a2);
            run_walk(va, asid, satp, zero_delay ? 0 : 3, zero_delay ? 0 : 3);
            chk("rnd_events", obs_events, 1);
            chk("rnd_update", obs_upd, e_upd);
            chk("rnd_fault", obs_flt, e_flt);
            if (e_flt) chk("rnd_fva", obs_fva, va);
            chk("rnd_nreq", obs_addr.size(), e_nreq);
            chk("rnd_a1", qget(0), e_a1);
            if (e_nreq == 2) chk("rnd_a2", qget(1), e_a2);
            chk("rnd_proto", obs_proto_err, 0);
            if (zero_delay) chk("rnd_latency", obs_lat, (e_nreq == 1) ? 3 : 5);
            chk("rnd_ready_end", miss_ready_o, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
